// File: rtl/ssd_score_scanner.sv
// Scans the score (ones, tens) and lives BCD digits onto an 8-digit common-anode display.
// Optional feature macro: SSD_LEADING_ZERO_BLANK_EN (blank a zero tens digit).
module ssd_score_scanner #(
    parameter int REFRESH_BITS = 18,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] score_ones,
    input  logic [3:0] score_tens,
    input  logic [3:0] lives,
    output logic [7:0] an,
    output logic [7:0] ssd
);

    localparam logic [3:0] BLINK_LOAD = 4'(BLINK_FRAMES);
    localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              sel;
    logic                    frame_end;
    logic [3:0]              snap_ones;
    logic [3:0]              snap_tens;
    logic [3:0]              snap_lives;
    logic [3:0]              blink_cnt;
    logic [7:0]              an_next;
    logic [7:0]              ssd_next;

    assign sel       = refresh_cnt[REFRESH_BITS-1 -: 2];
    assign frame_end = &refresh_cnt;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    // The lives snapshot about to be replaced is the previous frame's value,
    // so the incoming value is compared against it directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            snap_ones   <= '0;
            snap_tens   <= '0;
            snap_lives  <= '0;
            blink_cnt   <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_ONE;
            if (frame_end) begin
                snap_ones  <= score_ones;
                snap_tens  <= score_tens;
                snap_lives <= lives;
                if (lives < snap_lives)
                    blink_cnt <= BLINK_LOAD;
                else if (lives > snap_lives)
                    blink_cnt <= '0;
                else if (blink_cnt != 4'd0)
                    blink_cnt <= blink_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        an_next  = 8'hFF;
        ssd_next = 8'hFF;
        case (sel)
            2'd0: begin
                an_next  = 8'hFE;
                ssd_next = seg_of(snap_ones);
            end
            2'd1: begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
                if (snap_tens != 4'd0) begin
                    an_next  = 8'hFD;
                    ssd_next = seg_of(snap_tens);
                end
`else
                an_next  = 8'hFD;
                ssd_next = seg_of(snap_tens);
`endif
            end
            2'd3: begin
                // Odd blink counts blank the segments but keep the anode driven.
                an_next  = 8'hF7;
                ssd_next = (blink_cnt[0]) ? 8'hFF : seg_of(snap_lives);
            end
            default: begin
                an_next  = 8'hFF;
                ssd_next = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 8'hFF;
            ssd <= 8'hFF;
        end else begin
            an  <= an_next;
            ssd <= ssd_next;
        end
    end

endmodule

// File: tb/tb_ssd_score_scanner.sv
// Bench for ssd_score_scanner: frame-level reference model, per-cycle compare,
// literal checks of the display sequences and randomized digit traffic.
module tb_ssd_score_scanner;

    localparam int RB    = 4;
    localparam int BLINK = 4;
    localparam int FRAME = 1 << RB;
    localparam int SLOT  = FRAME / 4;

    logic       clk;
    logic       rst;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic [3:0] lives;
    logic [7:0] an;
    logic [7:0] ssd;

    int checks;
    int fails;

    ssd_score_scanner #(
        .REFRESH_BITS(RB),
        .BLINK_FRAMES(BLINK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .score_ones(score_ones),
        .score_tens(score_tens),
        .lives     (lives),
        .an        (an),
        .ssd       (ssd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] seven_seg(input logic [3:0] d);
        logic [7:0] table_v [0:9];
        table_v = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        if (d > 4'd9) return 8'hBF;
        return table_v[d];
    endfunction

    // Reference model: position within the frame, the digits latched for the
    // current frame, and how many blink frames remain.
    int         pos;
    int         disp_pos;
    int         blink_left;
    logic [3:0] shown_ones;
    logic [3:0] shown_tens;
    logic [3:0] shown_lives;
    logic [7:0] exp_an;
    logic [7:0] exp_ssd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos         = 0;
            disp_pos    = -1;
            blink_left  = 0;
            shown_ones  = 4'd0;
            shown_tens  = 4'd0;
            shown_lives = 4'd0;
            exp_an      = 8'hFF;
            exp_ssd     = 8'hFF;
        end else begin
            case (pos / SLOT)
                0: begin exp_an = 8'hFE; exp_ssd = seven_seg(shown_ones); end
                1: begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
                    if (shown_tens == 4'd0) begin exp_an = 8'hFF; exp_ssd = 8'hFF; end
                    else begin exp_an = 8'hFD; exp_ssd = seven_seg(shown_tens); end
`else
                    exp_an = 8'hFD; exp_ssd = seven_seg(shown_tens);
`endif
                end
                2: begin exp_an = 8'hFF; exp_ssd = 8'hFF; end
                default: begin
                    exp_an  = 8'hF7;
                    exp_ssd = (blink_left % 2 == 1) ? 8'hFF : seven_seg(shown_lives);
                end
            endcase
            disp_pos = pos;
            if (pos == FRAME - 1) begin
                if (lives < shown_lives)      blink_left = BLINK;
                else if (lives > shown_lives) blink_left = 0;
                else if (blink_left > 0)      blink_left = blink_left - 1;
                shown_ones  = score_ones;
                shown_tens  = score_tens;
                shown_lives = lives;
            end
            pos = (pos + 1) % FRAME;
        end
    end

    task automatic chk(input string name, input logic [7:0] a_an, input logic [7:0] a_ssd,
                       input logic [7:0] e_an, input logic [7:0] e_ssd);
        checks++;
        if (a_an !== e_an || a_ssd !== e_ssd) begin
            fails++;
            $display("FAIL %s t=%0t: an=%h ssd=%h, required an=%h ssd=%h",
                     name, $time, a_an, a_ssd, e_an, e_ssd);
        end
    endtask

    always @(negedge clk) begin
        if (rst) chk("reset_out", an, ssd, 8'hFF, 8'hFF);
        else if (disp_pos >= 0) chk("scan", an, ssd, exp_an, exp_ssd);
    end

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (disp_pos != target && n < 4 * FRAME);
        if (disp_pos != target) begin
            checks++;
            fails++;
            $display("FAIL wait_pos timeout: pos=%0d, required %0d", disp_pos, target);
        end
    endtask

    task automatic check_lit(input int target, input logic [7:0] e_an, input logic [7:0] e_ssd,
                             input string name);
        wait_pos(target);
        chk(name, an, ssd, e_an, e_ssd);
    endtask

    task automatic set_inputs(input logic [3:0] o, input logic [3:0] t, input logic [3:0] l);
        score_ones = o;
        score_tens = t;
        lives      = l;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        set_inputs(4'd0, 4'd0, 4'd0);
        repeat (3) @(negedge clk);
        chk("reset_hold", an, ssd, 8'hFF, 8'hFF);
        #1 rst = 1'b0;

        // First frame shows the reset snapshots even though inputs change.
        check_lit(1, 8'hFE, 8'hC0, "first_ones");
        set_inputs(4'd7, 4'd4, 4'd9);
        check_lit(5, 8'hFD, 8'hC0, "first_tens");
        check_lit(13, 8'hF7, 8'hC0, "first_lives");

        check_lit(1, 8'hFE, 8'hF8, "ones_7");
        check_lit(5, 8'hFD, 8'h99, "tens_4");
        check_lit(9, 8'hFF, 8'hFF, "slot2_blank");
        check_lit(13, 8'hF7, 8'h90, "lives_9");

        // Life lost: blink counts 4,3,2,1 then steady.
        set_inputs(4'd7, 4'd4, 4'd8);
        check_lit(13, 8'hF7, 8'h80, "blink_4");
        check_lit(13, 8'hF7, 8'hFF, "blink_3");
        check_lit(13, 8'hF7, 8'h80, "blink_2");
        check_lit(13, 8'hF7, 8'hFF, "blink_1");
        check_lit(13, 8'hF7, 8'h80, "blink_done");

        // Restart mid-blink cancels it.
        set_inputs(4'd7, 4'd4, 4'd7);
        check_lit(13, 8'hF7, 8'hF8, "blink_b4");
        set_inputs(4'd7, 4'd4, 4'd9);
        check_lit(13, 8'hF7, 8'h90, "cancel");
        check_lit(13, 8'hF7, 8'h90, "cancel_steady");

        set_inputs(4'hC, 4'd4, 4'd9);
        check_lit(1, 8'hFE, 8'hBF, "dash");

        set_inputs(4'd3, 4'd0, 4'd9);
        wait_pos(0);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        check_lit(5, 8'hFF, 8'hFF, "tens_zero");
`else
        check_lit(5, 8'hFD, 8'hC0, "tens_zero");
`endif
        check_lit(1, 8'hFE, 8'hB0, "ones_3");

        for (int f = 0; f < 20; f++) begin
            int r;
            logic [3:0] nl;
            repeat ($urandom_range(1, FRAME)) @(negedge clk);
            r  = $urandom_range(0, 3);
            nl = lives;
            if (r == 1 && nl > 0) nl = nl - 4'd1;
            else if (r == 2 && nl < 15) nl = nl + 4'd1;
            else if (r == 3) nl = 4'($urandom_range(0, 15));
            set_inputs(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), nl);
        end

        // Asynchronous reset in the lives slot.
        wait_pos(13);
        #2 rst = 1'b1;
        #1 chk("async_reset", an, ssd, 8'hFF, 8'hFF);
        @(negedge clk);
        #1 rst = 1'b0;
        check_lit(0, 8'hFE, 8'hC0, "restart_sel0");
        check_lit(13, 8'hF7, 8'hC0, "restart_lives");

        repeat (2 * FRAME) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
